// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks every row of an N_VARS-input truth table and streams the selected rows
// The mask and mode are captured at start, so the sweep cannot be disturbed once it is running.
module truth_table_sweeper #(
    parameter int N_VARS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(1<<N_VARS)-1:0]   func_mask,
    input  logic [1:0]               mode,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [N_VARS-1:0]        row_x,
    output logic                     row_s,
    output logic [N_VARS:0]          minterm_count,
    output logic [N_VARS:0]          maxterm_count,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N_VARS-1:0] LAST_IDX = '1;

    state_t                   r_state;
    state_t                   w_next;
    logic [N_VARS-1:0]        r_idx;
    logic [(1<<N_VARS)-1:0]   r_mask;
    logic [1:0]               r_mode;
    logic [N_VARS:0]          r_min;
    logic [N_VARS:0]          r_max;

    logic w_sweep;
    logic w_s;
    logic w_qual;
    logic w_adv;
    logic w_last;
    logic w_accept;

    assign w_sweep  = (r_state == S_SWEEP);
    assign w_s      = r_mask[r_idx];
    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && start;

    // Mode 11 behaves like 00: every row is emitted.
    always_comb begin
        w_qual = 1'b1;
        case (r_mode)
            2'b01:   w_qual = w_s;
            2'b10:   w_qual = !w_s;
            default: w_qual = 1'b1;
        endcase
    end

    // Non-qualifying rows advance unconditionally; qualifying ones wait for the consumer.
    assign w_adv = w_sweep && (!w_qual || row_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SWEEP;
            S_SWEEP: if (w_adv && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        row_valid     = w_sweep && w_qual;
        row_x         = w_sweep ? r_idx : '0;
        row_s         = w_sweep && w_s;
        busy          = w_sweep;
        done          = (r_state == S_DONE);
        minterm_count = r_min;
        maxterm_count = r_max;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_mask <= '0;
            r_mode <= 2'b00;
            r_min  <= '0;
            r_max  <= '0;
        end else if (w_accept) begin
            r_idx  <= '0;
            r_mask <= func_mask;
            r_mode <= mode;
            r_min  <= '0;
            r_max  <= '0;
        end else if (w_adv) begin
            r_min <= r_min + {{N_VARS{1'b0}}, w_s};
            r_max <= r_max + {{N_VARS{1'b0}}, !w_s};
            // Hold at the last row so the index never wraps inside a sweep.
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int N    = 3;
    localparam int ROWS = 1 << N;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [ROWS-1:0] func_mask;
    logic [1:0]      mode;
    logic            row_valid;
    logic            row_ready;
    logic [N-1:0]    row_x;
    logic            row_s;
    logic [N:0]      minterm_count;
    logic [N:0]      maxterm_count;
    logic            busy;
    logic            done;

    int tests = 0;
    int fails = 0;

    truth_table_sweeper #(.N_VARS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .func_mask     (func_mask),
        .mode          (mode),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_x         (row_x),
        .row_s         (row_s),
        .minterm_count (minterm_count),
        .maxterm_count (maxterm_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Reference: a row is listed when its function value matches the mode filter.
    function automatic bit row_selected(input logic [1:0] m, input bit s);
        if (m == 2'b01) return s;
        if (m == 2'b10) return !s;
        return 1'b1;
    endfunction

    // policy 0: ready always high; 1: random ready plus stray start pulses; 2: ready low for the first 3 cycles
    task automatic run_sweep(input logic [ROWS-1:0] mask, input logic [1:0] m, input int policy,
                             output int stalls, output int done_cyc);
        int exp_q[$];
        int obs_q[$];
        int cyc;
        int n_min;
        bit prev_stall;
        logic [N-1:0] px;
        logic ps;
        for (int i = 0; i < ROWS; i++) begin
            if (row_selected(m, mask[i])) exp_q.push_back(i * 2 + int'(mask[i]));
        end
        n_min = $countones(mask);
        func_mask = mask;
        mode      = m;
        start     = 1'b1;
        row_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        func_mask = ROWS'($urandom);
        mode      = 2'($urandom);
        cyc = 1;
        stalls = 0;
        done_cyc = 0;
        prev_stall = 1'b0;
        px = '0;
        ps = 1'b0;
        while (cyc < 200) begin
            case (policy)
                1: begin
                    row_ready = 1'($urandom_range(0, 1));
                    start     = ($urandom_range(0, 3) == 0);
                end
                2:       row_ready = (cyc > 3);
                default: row_ready = 1'b1;
            endcase
            #1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL busy_in_sweep: cycle %0d busy=%b expected 1", cyc, busy);
            end
            if (prev_stall) begin
                tests++;
                if (!(row_valid === 1'b1 && row_x === px && row_s === ps)) begin
                    fails++;
                    $display("FAIL hold_stable: cycle %0d got v=%b x=%0d s=%b expected v=1 x=%0d s=%b",
                             cyc, row_valid, row_x, row_s, px, ps);
                end
            end
            if (row_valid && row_ready) obs_q.push_back(int'(row_x) * 2 + int'(row_s));
            prev_stall = row_valid && !row_ready;
            if (prev_stall) stalls++;
            px = row_x;
            ps = row_s;
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (done_cyc != ROWS + 1 + stalls) begin
            fails++;
            $display("FAIL done_timing: done in cycle %0d expected %0d", done_cyc, ROWS + 1 + stalls);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL row_count: got %0d rows expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (obs_q[i] != exp_q[i]) begin
                    fails++;
                    $display("FAIL row_content[%0d]: got x=%0d s=%0d expected x=%0d s=%0d",
                             i, obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
                end
            end
        end
        tests++;
        if (minterm_count !== (N+1)'(n_min) || maxterm_count !== (N+1)'(ROWS - n_min) || busy !== 1'b0) begin
            fails++;
            $display("FAIL final_counts: got min=%0d max=%0d busy=%b expected min=%0d max=%0d busy=0",
                     minterm_count, maxterm_count, busy, n_min, ROWS - n_min);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || row_valid !== 1'b0 ||
            minterm_count !== (N+1)'(n_min) || maxterm_count !== (N+1)'(ROWS - n_min)) begin
            fails++;
            $display("FAIL idle_after_done: got done=%b busy=%b valid=%b min=%0d max=%0d expected 0 0 0 %0d %0d",
                     done, busy, row_valid, minterm_count, maxterm_count, n_min, ROWS - n_min);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if (row_valid !== 1'b0 || row_x !== '0 || row_s !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || minterm_count !== '0 || maxterm_count !== '0) begin
            fails++;
            $display("FAIL %s: got v=%b x=%0d s=%b busy=%b done=%b min=%0d max=%0d expected all 0",
                     name, row_valid, row_x, row_s, busy, done, minterm_count, maxterm_count);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b1;
        func_mask = '1;
        mode      = 2'b00;
        row_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_parity_all_rows();
        int st, dc;
        run_sweep(8'b1001_0110, 2'b00, 0, st, dc);
    endtask

    task automatic test_single_minterm();
        int st, dc;
        run_sweep(8'b0000_1000, 2'b01, 0, st, dc);
        tests++;
        if (dc != 9) begin
            fails++;
            $display("FAIL single_minterm_done: done in cycle %0d expected 9", dc);
        end
    endtask

    task automatic test_stall_maxterms();
        int st, dc;
        run_sweep(8'b1001_0110, 2'b10, 2, st, dc);
        tests++;
        if (st != 3) begin
            fails++;
            $display("FAIL stall_cycles: got %0d stalled cycles expected 3", st);
        end
    endtask

    task automatic test_no_emit();
        int st, dc;
        run_sweep(8'hFF, 2'b10, 0, st, dc);
        tests++;
        if (dc != 9) begin
            fails++;
            $display("FAIL no_emit_ones_done: done in cycle %0d expected 9", dc);
        end
        run_sweep(8'h00, 2'b01, 1, st, dc);
    endtask

    task automatic test_reset_midsweep();
        func_mask = 8'b1010_0101;
        mode      = 2'b00;
        row_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (row_x !== 3'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midsweep_position: got x=%0d busy=%b expected x=2 busy=1", row_x, busy);
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("reset_midsweep");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("idle_after_midsweep_reset");
    endtask

    task automatic test_random();
        int st, dc;
        for (int k = 0; k < 24; k++) begin
            run_sweep(ROWS'($urandom), 2'($urandom), 1, st, dc);
        end
    endtask

    task automatic test_back_to_back();
        int st, dc;
        run_sweep(8'b0110_1001, 2'b11, 0, st, dc);
        run_sweep(8'b1100_0011, 2'b01, 0, st, dc);
    endtask

    initial begin
        test_reset();
        test_parity_all_rows();
        test_single_minterm();
        test_stall_maxterms();
        test_no_emit();
        test_reset_midsweep();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
